// File: rtl/read_channel_scan_pkg.sv
// Shared definitions for the read-channel scan sequencer.
//   - scan_state_t : FSM state encoding
//   - CH_W, NUM_CHANNELS, LOAD_EDGES, EDGE_CNT_W : widths and counts
//   - one_hot64()  : channel number to [64:1] one-hot select; 0 for ch==0 or ch>64
package read_channel_scan_pkg;

    localparam int CH_W         = 7;
    localparam int NUM_CHANNELS = 64;
    localparam int LOAD_EDGES   = 64;   // Ck_Read rising edges per register load
    localparam int EDGE_CNT_W   = 7;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_LOAD   = 3'd2,
        ST_SETTLE = 3'd3,
        ST_SAMPLE = 3'd4,
        ST_NEXT   = 3'd5
    } scan_state_t;

    function automatic logic [NUM_CHANNELS:1] one_hot64(input logic [CH_W-1:0] ch);
        logic [NUM_CHANNELS:1] oh;
        oh = '0;
        for (int i = 1; i <= NUM_CHANNELS; i++) begin
            if (ch == CH_W'(i)) oh[i] = 1'b1;
        end
        return oh;
    endfunction

endpackage

// File: rtl/read_ck_edge_counter.sv
// Rising-edge detector and saturating counter for the loader's Ck_Read.
// Ports:
//   Clk, Rst_N : clock, async active-low reset
//   clear      : synchronous clear of the count (edge history still tracked)
//   ck_read    : loader serial clock, already in the Clk domain
//   count      : rising edges seen since the last clear, saturates at all-ones
module read_ck_edge_counter
    import read_channel_scan_pkg::*;
(
    input  logic                  Clk,
    input  logic                  Rst_N,
    input  logic                  clear,
    input  logic                  ck_read,
    output logic [EDGE_CNT_W-1:0] count
);

    logic ck_d;
    logic rise;

    assign rise = ck_read & ~ck_d;

    always_ff @(posedge Clk or negedge Rst_N) begin
        if (!Rst_N) begin
            ck_d  <= 1'b0;
            count <= '0;
        end else begin
            ck_d <= ck_read;
            if (clear) begin
                count <= '0;
            end else if (rise && (count != '1)) begin
                count <= count + EDGE_CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/read_channel_scan.sv
// Upstream sequencer for the ASIC read-register loader. Walks a channel range,
// driving a one-hot select and a start pulse per channel, waits for 64 Ck_Read
// edges, settles, then opens a sample window for the readout.
//
// Optional feature macro: SCAN_CHANNEL_MASK_EN adds In_Channel_Mask; masked
// channels are skipped (searched one channel per clock in NEXT).
//
// Ports:
//   Clk, Rst_N              clock, async active-low reset
//   In_Scan_Start/Stop      1-clk start / abort pulses
//   In_First/Last_Channel   scan range 1..64, sampled only at start
//   In_Continuous           wrap to first after last until stopped
//   In_Ck_Read              loader serial clock (monitored)
//   In_Channel_Mask         [64:1] skip mask (SCAN_CHANNEL_MASK_EN only)
//   Out_Enable_Register     loader enable, high while busy
//   Out_Choose_Channel      [64:1] one-hot channel select
//   Out_Start_Set_Register  1-clk loader start pulse
//   Out_Sample_Window       readout window, DWELL_CYCLES per channel
//   Out_Current_Channel     channel in progress, 0 when idle
//   Out_Scan_Busy           high outside IDLE
//   Out_Scan_Done           1-clk pulse at end of a single pass
//   Out_Error               1-clk pulse on bad range or load timeout
//
// state  | meaning
// IDLE   | waiting for start; all channel outputs cleared
// START  | start pulse and select driven for one clock; edge count cleared
// LOAD   | counting Ck_Read edges, bounded by LOAD_TIMEOUT
// SETTLE | SETTLE_CYCLES wait after load complete
// SAMPLE | sample window open for DWELL_CYCLES
// NEXT   | pick the next channel, wrap, or finish (mask search runs here)
module read_channel_scan
    import read_channel_scan_pkg::*;
#(
    parameter int SETTLE_CYCLES = 16,
    parameter int DWELL_CYCLES  = 64,
    parameter int LOAD_TIMEOUT  = 2048,
    parameter int CNT_W         = 12
) (
    input  logic                    Clk,
    input  logic                    Rst_N,
    input  logic                    In_Scan_Start,
    input  logic                    In_Scan_Stop,
    input  logic [CH_W-1:0]         In_First_Channel,
    input  logic [CH_W-1:0]         In_Last_Channel,
    input  logic                    In_Continuous,
    input  logic                    In_Ck_Read,
`ifdef SCAN_CHANNEL_MASK_EN
    input  logic [NUM_CHANNELS:1]   In_Channel_Mask,
`endif
    output logic                    Out_Enable_Register,
    output logic [NUM_CHANNELS:1]   Out_Choose_Channel,
    output logic                    Out_Start_Set_Register,
    output logic                    Out_Sample_Window,
    output logic [CH_W-1:0]         Out_Current_Channel,
    output logic                    Out_Scan_Busy,
    output logic                    Out_Scan_Done,
    output logic                    Out_Error
);

    scan_state_t           state_q;
    logic [CH_W-1:0]       first_q;
    logic [CH_W-1:0]       last_q;
    logic [CH_W-1:0]       ch_q;
    logic                  cont_q;
    logic [CNT_W-1:0]      timer_q;
    logic [EDGE_CNT_W-1:0] edge_count;
    logic                  edge_clr;
    logic                  range_bad;
    logic                  load_done;
    logic [CH_W-1:0]       succ_ch;
    logic [CH_W-1:0]       cand_ch;
    logic                  end_of_pass;

    assign edge_clr = (state_q == ST_START);

    read_ck_edge_counter u_edge_cnt (
        .Clk     (Clk),
        .Rst_N   (Rst_N),
        .clear   (edge_clr),
        .ck_read (In_Ck_Read),
        .count   (edge_count)
    );

    assign range_bad = (In_First_Channel == '0)
                    || (In_Last_Channel > CH_W'(NUM_CHANNELS))
                    || (In_First_Channel > In_Last_Channel);

    assign load_done = (edge_count >= EDGE_CNT_W'(LOAD_EDGES));
    assign succ_ch   = (ch_q < last_q) ? (ch_q + CH_W'(1)) : first_q;

`ifdef SCAN_CHANNEL_MASK_EN
    // adv_q: ch_q has been visited or rejected, so NEXT must move past it.
    // Clear only on scan start, where ch_q = first is itself a candidate.
    logic adv_q;
    logic cand_masked;

    assign cand_ch     = adv_q ? succ_ch : ch_q;
    assign end_of_pass = adv_q && (ch_q >= last_q) && !cont_q;
    assign cand_masked = |(In_Channel_Mask & one_hot64(cand_ch));
`else
    assign cand_ch     = succ_ch;
    assign end_of_pass = (ch_q >= last_q) && !cont_q;
`endif

    always_ff @(posedge Clk or negedge Rst_N) begin
        if (!Rst_N) begin
            state_q                <= ST_IDLE;
            first_q                <= '0;
            last_q                 <= '0;
            ch_q                   <= '0;
            cont_q                 <= 1'b0;
            timer_q                <= '0;
            Out_Enable_Register    <= 1'b0;
            Out_Choose_Channel     <= '0;
            Out_Start_Set_Register <= 1'b0;
            Out_Sample_Window      <= 1'b0;
            Out_Current_Channel    <= '0;
            Out_Scan_Busy          <= 1'b0;
            Out_Scan_Done          <= 1'b0;
            Out_Error              <= 1'b0;
`ifdef SCAN_CHANNEL_MASK_EN
            adv_q                  <= 1'b0;
`endif
        end else begin
            Out_Start_Set_Register <= 1'b0;
            Out_Scan_Done          <= 1'b0;
            Out_Error              <= 1'b0;

            if (In_Scan_Stop && (state_q != ST_IDLE)) begin
                state_q             <= ST_IDLE;
                ch_q                <= '0;
                Out_Enable_Register <= 1'b0;
                Out_Choose_Channel  <= '0;
                Out_Sample_Window   <= 1'b0;
                Out_Current_Channel <= '0;
                Out_Scan_Busy       <= 1'b0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        // A simultaneous stop cancels the start outright.
                        if (In_Scan_Start && !In_Scan_Stop) begin
                            if (range_bad) begin
                                Out_Error <= 1'b1;
                            end else begin
                                first_q             <= In_First_Channel;
                                last_q              <= In_Last_Channel;
                                cont_q              <= In_Continuous;
                                ch_q                <= In_First_Channel;
                                Out_Current_Channel <= In_First_Channel;
                                Out_Scan_Busy       <= 1'b1;
                                Out_Enable_Register <= 1'b1;
`ifdef SCAN_CHANNEL_MASK_EN
                                adv_q               <= 1'b0;
                                state_q             <= ST_NEXT;
`else
                                Out_Choose_Channel     <= one_hot64(In_First_Channel);
                                Out_Start_Set_Register <= 1'b1;
                                state_q                <= ST_START;
`endif
                            end
                        end
                    end

                    ST_START: begin
                        timer_q <= CNT_W'(LOAD_TIMEOUT - 1);
                        state_q <= ST_LOAD;
                    end

                    ST_LOAD: begin
                        // Timer loaded in START reaches 1 on the clock that makes
                        // the error pulse land LOAD_TIMEOUT clocks after the start pulse.
                        if (load_done) begin
                            timer_q <= CNT_W'(SETTLE_CYCLES - 1);
                            state_q <= ST_SETTLE;
                        end else if (timer_q <= CNT_W'(1)) begin
                            Out_Error           <= 1'b1;
                            state_q             <= ST_IDLE;
                            ch_q                <= '0;
                            Out_Enable_Register <= 1'b0;
                            Out_Choose_Channel  <= '0;
                            Out_Current_Channel <= '0;
                            Out_Scan_Busy       <= 1'b0;
                        end else begin
                            timer_q <= timer_q - CNT_W'(1);
                        end
                    end

                    ST_SETTLE: begin
                        if (timer_q == '0) begin
                            Out_Sample_Window <= 1'b1;
                            timer_q           <= CNT_W'(DWELL_CYCLES - 1);
                            state_q           <= ST_SAMPLE;
                        end else begin
                            timer_q <= timer_q - CNT_W'(1);
                        end
                    end

                    ST_SAMPLE: begin
                        if (timer_q == '0) begin
                            Out_Sample_Window <= 1'b0;
                            state_q           <= ST_NEXT;
`ifdef SCAN_CHANNEL_MASK_EN
                            adv_q             <= 1'b1;
`endif
                        end else begin
                            timer_q <= timer_q - CNT_W'(1);
                        end
                    end

                    ST_NEXT: begin
                        if (end_of_pass) begin
                            Out_Scan_Done       <= 1'b1;
                            state_q             <= ST_IDLE;
                            ch_q                <= '0;
                            Out_Enable_Register <= 1'b0;
                            Out_Choose_Channel  <= '0;
                            Out_Current_Channel <= '0;
                            Out_Scan_Busy       <= 1'b0;
`ifdef SCAN_CHANNEL_MASK_EN
                        end else if (cand_masked) begin
                            // Step past one masked channel per clock; in continuous
                            // mode with everything masked this loops until stop.
                            ch_q                <= cand_ch;
                            Out_Current_Channel <= cand_ch;
                            adv_q               <= 1'b1;
`endif
                        end else begin
                            ch_q                   <= cand_ch;
                            Out_Current_Channel    <= cand_ch;
                            Out_Choose_Channel     <= one_hot64(cand_ch);
                            Out_Start_Set_Register <= 1'b1;
                            state_q                <= ST_START;
                        end
                    end

                    default: begin
                        state_q <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_read_channel_scan.sv
module tb_read_channel_scan;

    localparam int SETTLE = 2;
    localparam int DWELL  = 4;
    localparam int TMO    = 200;

    logic        Clk;
    logic        Rst_N;
    logic        In_Scan_Start;
    logic        In_Scan_Stop;
    logic [6:0]  In_First_Channel;
    logic [6:0]  In_Last_Channel;
    logic        In_Continuous;
    logic        In_Ck_Read;
`ifdef SCAN_CHANNEL_MASK_EN
    logic [64:1] In_Channel_Mask;
`endif
    logic        Out_Enable_Register;
    logic [64:1] Out_Choose_Channel;
    logic        Out_Start_Set_Register;
    logic        Out_Sample_Window;
    logic [6:0]  Out_Current_Channel;
    logic        Out_Scan_Busy;
    logic        Out_Scan_Done;
    logic        Out_Error;

    int n_cmp  = 0;
    int n_fail = 0;
    int loader_edges = 64;

    read_channel_scan #(
        .SETTLE_CYCLES (SETTLE),
        .DWELL_CYCLES  (DWELL),
        .LOAD_TIMEOUT  (TMO),
        .CNT_W         (12)
    ) dut (
        .Clk                    (Clk),
        .Rst_N                  (Rst_N),
        .In_Scan_Start          (In_Scan_Start),
        .In_Scan_Stop           (In_Scan_Stop),
        .In_First_Channel       (In_First_Channel),
        .In_Last_Channel        (In_Last_Channel),
        .In_Continuous          (In_Continuous),
        .In_Ck_Read             (In_Ck_Read),
`ifdef SCAN_CHANNEL_MASK_EN
        .In_Channel_Mask        (In_Channel_Mask),
`endif
        .Out_Enable_Register    (Out_Enable_Register),
        .Out_Choose_Channel     (Out_Choose_Channel),
        .Out_Start_Set_Register (Out_Start_Set_Register),
        .Out_Sample_Window      (Out_Sample_Window),
        .Out_Current_Channel    (Out_Current_Channel),
        .Out_Scan_Busy          (Out_Scan_Busy),
        .Out_Scan_Done          (Out_Scan_Done),
        .Out_Error              (Out_Error)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Loader model: after each start pulse, produce loader_edges Ck_Read pulses
    // (one rising edge every two clocks).
    initial begin
        In_Ck_Read = 1'b0;
        forever begin
            @(posedge Clk); #1;
            if (Out_Start_Set_Register === 1'b1) begin
                for (int e = 0; e < loader_edges; e++) begin
                    @(posedge Clk); #1; In_Ck_Read = 1'b1;
                    @(posedge Clk); #1; In_Ck_Read = 1'b0;
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [64:1] oh(input int ch);
        logic [64:1] r;
        r = '0;
        if (ch >= 1 && ch <= 64) r[ch] = 1'b1;
        return r;
    endfunction

    task automatic test_reset();
        Rst_N = 1'b0;
        In_Scan_Start = 1'b0; In_Scan_Stop = 1'b0; In_Continuous = 1'b0;
        In_First_Channel = 7'd1; In_Last_Channel = 7'd1;
`ifdef SCAN_CHANNEL_MASK_EN
        In_Channel_Mask = '0;
`endif
        repeat (3) @(negedge Clk);
        n_cmp++; if (Out_Enable_Register !== 1'b0) begin n_fail++; $display("FAIL reset_enable got=%b exp=0", Out_Enable_Register); end
        n_cmp++; if (Out_Choose_Channel !== 64'h0) begin n_fail++; $display("FAIL reset_choose got=%h exp=0", Out_Choose_Channel); end
        n_cmp++; if (Out_Start_Set_Register !== 1'b0) begin n_fail++; $display("FAIL reset_start got=%b exp=0", Out_Start_Set_Register); end
        n_cmp++; if (Out_Sample_Window !== 1'b0) begin n_fail++; $display("FAIL reset_window got=%b exp=0", Out_Sample_Window); end
        n_cmp++; if (Out_Current_Channel !== 7'd0) begin n_fail++; $display("FAIL reset_channel got=%0d exp=0", Out_Current_Channel); end
        n_cmp++; if (Out_Scan_Busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", Out_Scan_Busy); end
        n_cmp++; if (Out_Scan_Done !== 1'b0) begin n_fail++; $display("FAIL reset_done got=%b exp=0", Out_Scan_Done); end
        n_cmp++; if (Out_Error !== 1'b0) begin n_fail++; $display("FAIL reset_error got=%b exp=0", Out_Error); end
        Rst_N = 1'b1;
        repeat (2) @(negedge Clk);
        n_cmp++; if (Out_Scan_Busy !== 1'b0) begin n_fail++; $display("FAIL post_reset_busy got=%b exp=0", Out_Scan_Busy); end
    endtask

    // Single-pass scan with scoreboard of expected start channels; optional
    // start pokes (with a different range) while busy must be ignored.
    task automatic test_single_pass(input int first, input int last,
                                    input logic [64:1] mask, input bit poke);
        int exp_q[$];
        int n_exp, cur, wlen, starts, windows, dones, errors;
        bit finished;
        for (int c = first; c <= last; c++) if (!mask[c]) exp_q.push_back(c);
        n_exp = exp_q.size();
        cur = 0; wlen = 0; starts = 0; windows = 0; dones = 0; errors = 0; finished = 0;
        In_First_Channel = 7'(first); In_Last_Channel = 7'(last); In_Continuous = 1'b0;
`ifdef SCAN_CHANNEL_MASK_EN
        In_Channel_Mask = mask;
`endif
        @(negedge Clk); In_Scan_Start = 1'b1;
        @(negedge Clk); In_Scan_Start = 1'b0;
        for (int cyc = 0; cyc < 3000 && !finished; cyc++) begin
            if (cyc > 0) @(negedge Clk);
            if (Out_Start_Set_Register === 1'b1) begin
                starts++;
                if (exp_q.size() == 0) begin
                    n_cmp++; n_fail++;
                    $display("FAIL pass_%0d_%0d_extra_start got_channel=%0d exp=none", first, last, Out_Current_Channel);
                end else begin
                    cur = exp_q.pop_front();
                    n_cmp++; if (Out_Choose_Channel !== oh(cur)) begin n_fail++; $display("FAIL pass_%0d_%0d_choose got=%h exp=%h", first, last, Out_Choose_Channel, oh(cur)); end
                    n_cmp++; if (Out_Current_Channel !== 7'(cur)) begin n_fail++; $display("FAIL pass_%0d_%0d_current got=%0d exp=%0d", first, last, Out_Current_Channel, cur); end
                end
            end
            if (Out_Sample_Window === 1'b1) begin
                wlen++;
                n_cmp++; if (Out_Choose_Channel !== oh(cur)) begin n_fail++; $display("FAIL pass_%0d_%0d_choose_hold got=%h exp=%h", first, last, Out_Choose_Channel, oh(cur)); end
            end else if (wlen != 0) begin
                n_cmp++; if (wlen != DWELL) begin n_fail++; $display("FAIL pass_%0d_%0d_window_len got=%0d exp=%0d", first, last, wlen, DWELL); end
                windows++; wlen = 0;
            end
            if (Out_Error === 1'b1) errors++;
            if (Out_Scan_Done === 1'b1) begin
                dones++; finished = 1;
                n_cmp++; if (Out_Scan_Busy !== 1'b0) begin n_fail++; $display("FAIL pass_%0d_%0d_busy_at_done got=%b exp=0", first, last, Out_Scan_Busy); end
            end
            if (poke && (cyc == 20 || cyc == 160 || cyc == 300)) begin
                In_First_Channel = 7'd1; In_Last_Channel = 7'd2; In_Scan_Start = 1'b1;
            end else begin
                In_Scan_Start = 1'b0;
            end
        end
        In_Scan_Start = 1'b0;
        n_cmp++; if (!finished) begin n_fail++; $display("FAIL pass_%0d_%0d_done_timeout got=no_done exp=done", first, last); end
        n_cmp++; if (starts != n_exp) begin n_fail++; $display("FAIL pass_%0d_%0d_starts got=%0d exp=%0d", first, last, starts, n_exp); end
        n_cmp++; if (windows != n_exp) begin n_fail++; $display("FAIL pass_%0d_%0d_windows got=%0d exp=%0d", first, last, windows, n_exp); end
        n_cmp++; if (errors != 0) begin n_fail++; $display("FAIL pass_%0d_%0d_errors got=%0d exp=0", first, last, errors); end
        n_cmp++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL pass_%0d_%0d_missing got_left=%0d exp=0", first, last, exp_q.size()); end
        @(negedge Clk);
        n_cmp++; if (Out_Scan_Done !== 1'b0) begin n_fail++; $display("FAIL pass_%0d_%0d_done_width got=%b exp=0", first, last, Out_Scan_Done); end
        n_cmp++; if (Out_Choose_Channel !== 64'h0 || Out_Current_Channel !== 7'd0) begin n_fail++; $display("FAIL pass_%0d_%0d_idle_outputs got=%h/%0d exp=0/0", first, last, Out_Choose_Channel, Out_Current_Channel); end
`ifdef SCAN_CHANNEL_MASK_EN
        In_Channel_Mask = '0;
`endif
        repeat (3) @(negedge Clk);
    endtask

    task automatic test_bad_range();
        int fa[3];
        int la[3];
        int errs, starts;
        bit busy_seen;
        fa[0] = 0; la[0] = 4;
        fa[1] = 9; la[1] = 4;
        fa[2] = 1; la[2] = 65;
        for (int i = 0; i < 3; i++) begin
            errs = 0; starts = 0; busy_seen = 0;
            In_First_Channel = 7'(fa[i]); In_Last_Channel = 7'(la[i]);
            @(negedge Clk); In_Scan_Start = 1'b1;
            @(negedge Clk); In_Scan_Start = 1'b0;
            for (int c = 0; c < 8; c++) begin
                if (c > 0) @(negedge Clk);
                if (Out_Error === 1'b1) errs++;
                if (Out_Scan_Busy === 1'b1) busy_seen = 1;
                if (Out_Start_Set_Register === 1'b1) starts++;
            end
            n_cmp++; if (errs != 1) begin n_fail++; $display("FAIL bad_range_%0d_%0d_error_pulses got=%0d exp=1", fa[i], la[i], errs); end
            n_cmp++; if (busy_seen) begin n_fail++; $display("FAIL bad_range_%0d_%0d_busy got=1 exp=0", fa[i], la[i]); end
            n_cmp++; if (starts != 0) begin n_fail++; $display("FAIL bad_range_%0d_%0d_starts got=%0d exp=0", fa[i], la[i], starts); end
        end
    endtask

    task automatic test_start_stop_same();
        int starts, errs;
        bit busy_seen;
        starts = 0; errs = 0; busy_seen = 0;
        In_First_Channel = 7'd2; In_Last_Channel = 7'd3;
        @(negedge Clk); In_Scan_Start = 1'b1; In_Scan_Stop = 1'b1;
        @(negedge Clk); In_Scan_Start = 1'b0; In_Scan_Stop = 1'b0;
        for (int c = 0; c < 8; c++) begin
            if (c > 0) @(negedge Clk);
            if (Out_Scan_Busy === 1'b1) busy_seen = 1;
            if (Out_Start_Set_Register === 1'b1) starts++;
            if (Out_Error === 1'b1) errs++;
        end
        n_cmp++; if (busy_seen) begin n_fail++; $display("FAIL start_stop_busy got=1 exp=0"); end
        n_cmp++; if (starts != 0) begin n_fail++; $display("FAIL start_stop_starts got=%0d exp=0", starts); end
        n_cmp++; if (errs != 0) begin n_fail++; $display("FAIL start_stop_errors got=%0d exp=0", errs); end
    endtask

    task automatic test_timeout();
        int t0, terr, dones;
        t0 = -1; terr = -1; dones = 0;
        loader_edges = 10;
        In_First_Channel = 7'd7; In_Last_Channel = 7'd7; In_Continuous = 1'b0;
        @(negedge Clk); In_Scan_Start = 1'b1;
        @(negedge Clk); In_Scan_Start = 1'b0;
        for (int cyc = 0; cyc < 500; cyc++) begin
            if (cyc > 0) @(negedge Clk);
            if (Out_Start_Set_Register === 1'b1 && t0 < 0) t0 = cyc;
            if (Out_Scan_Done === 1'b1) dones++;
            if (Out_Error === 1'b1 && terr < 0) begin
                terr = cyc;
                n_cmp++; if (Out_Scan_Busy !== 1'b0) begin n_fail++; $display("FAIL timeout_busy got=%b exp=0", Out_Scan_Busy); end
                n_cmp++; if (Out_Choose_Channel !== 64'h0) begin n_fail++; $display("FAIL timeout_choose got=%h exp=0", Out_Choose_Channel); end
            end
            if (terr >= 0 && cyc > terr + 10) break;
        end
        n_cmp++; if (t0 < 0 || terr < 0 || (terr - t0) != TMO) begin n_fail++; $display("FAIL timeout_latency got=%0d exp=%0d", terr - t0, TMO); end
        n_cmp++; if (dones != 0) begin n_fail++; $display("FAIL timeout_done got=%0d exp=0", dones); end
        loader_edges = 64;
        repeat (3) @(negedge Clk);
    endtask

    task automatic test_continuous_stop();
        int exp_q[$];
        int starts, wlen, got, stray;
        bit stopped, checked;
        starts = 0; wlen = 0; stopped = 0; checked = 0; stray = 0;
        exp_q.push_back(63); exp_q.push_back(64); exp_q.push_back(63); exp_q.push_back(64);
        In_First_Channel = 7'd63; In_Last_Channel = 7'd64; In_Continuous = 1'b1;
        @(negedge Clk); In_Scan_Start = 1'b1;
        @(negedge Clk); In_Scan_Start = 1'b0;
        for (int cyc = 0; cyc < 2000 && !checked; cyc++) begin
            if (cyc > 0) @(negedge Clk);
            if (stopped) begin
                In_Scan_Stop = 1'b0;
                checked = 1;
                n_cmp++; if (Out_Sample_Window !== 1'b0) begin n_fail++; $display("FAIL cont_stop_window got=%b exp=0", Out_Sample_Window); end
                n_cmp++; if (Out_Scan_Busy !== 1'b0) begin n_fail++; $display("FAIL cont_stop_busy got=%b exp=0", Out_Scan_Busy); end
                n_cmp++; if (Out_Current_Channel !== 7'd0) begin n_fail++; $display("FAIL cont_stop_channel got=%0d exp=0", Out_Current_Channel); end
            end else begin
                if (Out_Start_Set_Register === 1'b1) begin
                    starts++;
                    got = int'(Out_Current_Channel);
                    if (exp_q.size() == 0) begin
                        n_cmp++; n_fail++; $display("FAIL cont_extra_start got=%0d exp=none", got);
                    end else begin
                        n_cmp++; if (got != exp_q[0]) begin n_fail++; $display("FAIL cont_sequence got=%0d exp=%0d", got, exp_q[0]); end
                        void'(exp_q.pop_front());
                    end
                end
                if (Out_Sample_Window === 1'b1) wlen++; else wlen = 0;
                if (starts == 4 && wlen == 2) begin
                    In_Scan_Stop = 1'b1; stopped = 1;
                end
            end
        end
        In_Scan_Stop = 1'b0;
        n_cmp++; if (!checked) begin n_fail++; $display("FAIL cont_stop_reached got=no exp=yes"); end
        n_cmp++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL cont_missing got_left=%0d exp=0", exp_q.size()); end
        for (int c = 0; c < 30; c++) begin
            @(negedge Clk);
            if (Out_Scan_Done === 1'b1 || Out_Error === 1'b1 || Out_Start_Set_Register === 1'b1) stray++;
        end
        n_cmp++; if (stray != 0) begin n_fail++; $display("FAIL cont_after_stop_activity got=%0d exp=0", stray); end
        In_Continuous = 1'b0;
    endtask

    initial begin
        logic [64:1] m;
        test_reset();
        test_single_pass(3, 5, '0, 1'b0);
        test_single_pass(64, 64, '0, 1'b0);
        test_bad_range();
        test_start_stop_same();
        test_timeout();
        test_single_pass(10, 12, '0, 1'b1);
        test_continuous_stop();
`ifdef SCAN_CHANNEL_MASK_EN
        m = '0; m[2] = 1'b1; m[3] = 1'b1;
        test_single_pass(1, 4, m, 1'b0);
        m = '0; m[1] = 1'b1; m[2] = 1'b1; m[3] = 1'b1; m[4] = 1'b1;
        test_single_pass(1, 4, m, 1'b0);
`else
        m = '0;
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
